// File: rtl/fifo_bus_sel_arbiter_pkg.sv
// Shared definitions for the bus_sel fabric: state encoding and default
// sizes used by the interconnect, the dispatchers and the FIFO-side arbiter.
package bus_sel_pkg;

  localparam int unsigned PORT_NUM_DEF = 2;
  localparam int unsigned DATA_W_DEF   = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Index width for a port number; never zero so a 1-port build still elaborates.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_bus_sel_arbiter_if.sv
// Dispatcher-to-FIFO bundle for one FIFO: request/beat lanes per dispatcher
// plus the FIFO write port. slave = the arbiter, master = the surroundings.
interface fifo_bus_sel_arbiter_if
  import bus_sel_pkg::*;
#(
  parameter int unsigned PORT_NUM = PORT_NUM_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
);

  logic [PORT_NUM-1:0]        bus_sel;
  logic [PORT_NUM*DATA_W-1:0] fd_data;
  logic [PORT_NUM-1:0]        fd_valid;
  logic [PORT_NUM-1:0]        fd_last;
  logic [PORT_NUM-1:0]        fd_ready;
  logic [PORT_NUM-1:0]        grant;
  logic                       fifo_full;
  logic                       fifo_wr_en;
  logic [DATA_W-1:0]          fifo_wr_data;
  logic                       busy;
  logic                       timeout_err;

  modport slave (
    input  bus_sel, fd_data, fd_valid, fd_last, fifo_full,
    output fd_ready, grant, fifo_wr_en, fifo_wr_data, busy, timeout_err
  );

  modport master (
    output bus_sel, fd_data, fd_valid, fd_last, fifo_full,
    input  fd_ready, grant, fifo_wr_en, fifo_wr_data, busy, timeout_err
  );

endinterface

// File: rtl/fifo_bus_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping. Shared with the dispatcher-side FIFO selector.
module rr_pick
  import bus_sel_pkg::*;
#(
  parameter  int unsigned N  = PORT_NUM_DEF,
  localparam int unsigned PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW-1:0] j;

  always_comb begin
    sel   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = PW'((32'(ptr) + i) % N);
      if (!valid && req[j]) begin
        valid  = 1'b1;
        sel[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/fifo_bus_sel_arbiter.sv
// FIFO-side arbiter: round-robin grant locked for a whole frame, beat mux into
// the FIFO write port. Optional idle watchdog: define BUS_SEL_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner; arbitrate bus_sel from rr_ptr
// LOCK    | owner holds the FIFO until last beat, abort or watchdog
module fifo_bus_sel_arbiter
  import bus_sel_pkg::*;
#(
  parameter int unsigned PORT_NUM  = PORT_NUM_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned TIMEOUT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  fifo_bus_sel_arbiter_if.slave bus
);

  localparam int unsigned PW = ptr_w(PORT_NUM);

  if (TIMEOUT_W < 1) begin : g_bad_cfg
    $error("TIMEOUT_W must be at least 1");
  end

  state_t              state_q, state_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [PORT_NUM-1:0] pick_sel;
  logic [PW-1:0]       pick_idx;
  logic                pick_valid;

  logic [DATA_W-1:0]   fd_data_arr [PORT_NUM];
  logic                locked, accept, release_hit, tmo_hit;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_unpack
    assign fd_data_arr[i] = bus.fd_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.N(PORT_NUM)) u_pick (
    .req   (bus.bus_sel),
    .ptr   (rr_ptr_q),
    .sel   (pick_sel),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign locked = (state_q == ST_LOCK);
  // Ready is combinational from fifo_full; the FIFO's spare entry covers the
  // registered write already in flight when full rises.
  assign bus.fd_ready = grant_q & {PORT_NUM{~bus.fifo_full}};
  assign accept       = locked & bus.fd_valid[owner_q] & ~bus.fifo_full;
  assign release_hit  = locked & ((accept & bus.fd_last[owner_q]) |
                                  ~bus.bus_sel[owner_q] | tmo_hit);

`ifdef BUS_SEL_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic                 tmo_err_q;

  assign tmo_hit = locked & (tmo_cnt_q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit;
      if (!locked || accept)
        tmo_cnt_q <= '0;
      else if (!bus.fifo_full)
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = accept;
    wr_data_d = accept ? fd_data_arr[owner_q] : wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_LOCK;
          grant_d = pick_sel;
          owner_d = pick_idx;
        end
      end
      ST_LOCK: begin
        if (release_hit) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == PW'(PORT_NUM - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = locked;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule
